debugger_tx: RTL and testbench

Transmit half of the UART debug unit. When the debugger control FSM raises `sendSignal`, this block snapshots the wide pipeline-state vector `sendData`. It streams the snapshot byte by byte into the UART transmit FIFO, honouring `tx_full`. When the last byte is accepted it pulses `dataSent`, which lets the control FSM leave SENDING and return to WAITING.

---
 rtl/debugger_tx.sv | 117 +++++++++++
 tb/tb_debugger_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_tx.sv
// debugger_tx: transmit half of the UART debug unit.
// On a request from the debugger control FSM, snapshot the wide pipeline-state
// vector and stream it LSB byte first into the UART TX FIFO, honouring tx_full.
// When the last byte has been accepted, pulse dataSent for one cycle. Then wait
// for the request level to drop before arming again.
module debugger_tx #(
  parameter int NUM_BYTES = 220,
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sendSignal,
  input  logic [8*NUM_BYTES-1:0] sendData,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   dataSent,
  output logic                   busy
);

  // Encoding is fixed so the state is easy to read on a debug probe.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int                 SHIFT_W  = 8 * NUM_BYTES;
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [SHIFT_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;

  // Snapshot moved down by one byte lane, with zero fill in the top lane.
  logic [SHIFT_W-1:0] shift_down;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      if (gi == NUM_BYTES - 1) begin : g_top
        assign shift_down[8*gi +: 8] = 8'h00;
      end else begin : g_mid
        assign shift_down[8*gi +: 8] = shift_reg[8*(gi+1) +: 8];
      end
    end
  endgenerate

  // State, snapshot and byte counter; reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and outputs. wr_uart follows tx_full combinationally
  // so the FIFO is never written while it reports full.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    wr_uart    = 1'b0;
    dataSent   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (sendSignal) begin
          shift_next = sendData;
          cnt_next   = '0;
          state_next = SEND;
        end
      end

      SEND: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          shift_next = shift_down;
          cnt_next   = cnt_reg + CNT_ONE;
          if (cnt_reg == LAST_IDX) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        dataSent   = 1'b1;
        state_next = RELEASE;
      end

      RELEASE: begin
        // The control FSM may still be holding the request; do not retrigger.
        if (!sendSignal) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The presented byte is always the bottom lane of the snapshot.
  always_comb begin
    w_data = shift_reg[7:0];
    busy   = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_debugger_tx.sv
// tb_debugger_tx: directed/randomized bench for debugger_tx.
// A 4-byte instance covers reset, timing, backpressure, handshake, snapshot
// and abort; a default 220-byte instance covers a long frame under random
// tx_full. Expected bytes come from the requested data vector and expected
// latency from counting the cycles in which tx_full was asserted.
module tb_debugger_tx;

  localparam int NB_S = 4;
  localparam int NB_L = 220;

  logic clock = 1'b0;
  logic reset;

  logic              ss_s, full_s, wr_s, ds_s, busy_s;
  logic [8*NB_S-1:0] sd_s;
  logic [7:0]        wd_s;

  logic              ss_l, full_l, wr_l, ds_l, busy_l;
  logic [8*NB_L-1:0] sd_l;
  logic [7:0]        wd_l;

  int n_checks = 0;
  int n_fail   = 0;

  bit sel_l = 1'b0;
  byte unsigned got_q[$];

  logic       wr_m, ds_m, busy_m;
  logic [7:0] wd_m;

  assign wr_m   = sel_l ? wr_l   : wr_s;
  assign ds_m   = sel_l ? ds_l   : ds_s;
  assign busy_m = sel_l ? busy_l : busy_s;
  assign wd_m   = sel_l ? wd_l   : wd_s;

  always #5 clock = ~clock;

  debugger_tx #(.NUM_BYTES(NB_S), .CNT_W(8)) u_small (
    .clock      (clock),
    .reset      (reset),
    .sendSignal (ss_s),
    .sendData   (sd_s),
    .tx_full    (full_s),
    .wr_uart    (wr_s),
    .w_data     (wd_s),
    .dataSent   (ds_s),
    .busy       (busy_s)
  );

  debugger_tx u_large (
    .clock      (clock),
    .reset      (reset),
    .sendSignal (ss_l),
    .sendData   (sd_l),
    .tx_full    (full_l),
    .wr_uart    (wr_l),
    .w_data     (wd_l),
    .dataSent   (ds_l),
    .busy       (busy_l)
  );

  // Record every byte the FIFO would accept on this edge.
  always @(posedge clock) begin
    if (wr_m === 1'b1) got_q.push_back(wd_m);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit big, input logic ss, input logic [8*NB_L-1:0] data, input logic f);
    if (big) begin
      ss_l = ss; sd_l = data; full_l = f;
    end else begin
      ss_s = ss; sd_s = data[8*NB_S-1:0]; full_s = f;
    end
  endtask

  task automatic set_full(input bit big, input logic f);
    if (big) full_l = f; else full_s = f;
  endtask

  // One request. mode: 0 no stall, 1 stall 3 cycles after byte 1,
  // 2 random tx_full, 3 no stall but sendData altered after byte 1.
  // abort_after >= 0 pulls reset once that many bytes are accepted.
  task automatic run_frame(input bit big, input logic [8*NB_L-1:0] data,
                           input int mode, input int abort_after);
    int nb;
    int i;
    int stalls;
    int c;
    bit done;
    bit f;
    byte unsigned exp_q[$];
    nb = big ? NB_L : NB_S;
    i = 0; stalls = 0; c = 0; done = 1'b0;
    for (int k = 0; k < nb; k++) exp_q.push_back(data[8*k +: 8]);
    sel_l = big;
    got_q.delete();
    drive(big, 1'b1, data, 1'b0);
    step();                                  // request edge E0
    while (!done && c < 4*nb + 20) begin
      c++;
      case (mode)
        1:       f = (i == 2 && stalls < 3);
        2:       f = 1'($urandom_range(0, 1));
        default: f = 1'b0;
      endcase
      if (i >= nb) f = 1'($urandom_range(0, 1));
      set_full(big, f);
      if (mode == 3 && i == 2) sd_s = ~data[8*NB_S-1:0];
      if (abort_after >= 0 && i == abort_after) begin
        reset = 1'b0;
        ss_s  = 1'b0;
        #1;
        chk("abort_wr",   {31'd0, wr_m},   32'd0);
        chk("abort_busy", {31'd0, busy_m}, 32'd0);
        chk("abort_ds",   {31'd0, ds_m},   32'd0);
        for (int r = 0; r < 2; r++) begin
          step();
          chk("abort_hold_ds", {31'd0, ds_m}, 32'd0);
          chk("abort_hold_wr", {31'd0, wr_m}, 32'd0);
        end
        reset = 1'b1;
        chk("abort_count", got_q.size(), abort_after);
        for (int k = 0; k < abort_after && k < got_q.size(); k++)
          chk($sformatf("abort_byte%0d", k), {24'd0, got_q[k]}, {24'd0, exp_q[k]});
        return;
      end
      #1;
      if (i < nb) begin
        chk("wr_uart", {31'd0, wr_m}, {31'd0, ~f});
        if (!f) chk($sformatf("w_data%0d", i), {24'd0, wd_m}, {24'd0, exp_q[i]});
        chk("ds_early", {31'd0, ds_m}, 32'd0);
        chk("busy_send", {31'd0, busy_m}, 32'd1);
        if (!f) i++; else stalls++;
      end else begin
        chk("wr_done",   {31'd0, wr_m},   32'd0);
        chk("ds_pulse",  {31'd0, ds_m},   32'd1);
        chk("busy_done", {31'd0, busy_m}, 32'd1);
        chk("latency",   c, nb + 1 + stalls);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("frame_timeout", 32'd0, 32'd1);
    set_full(big, 1'b0);
    chk("frame_count", got_q.size(), nb);
    for (int k = 0; k < nb && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k])
        chk($sformatf("frame_byte%0d", k), {24'd0, got_q[k]}, {24'd0, exp_q[k]});
    chk("ds_single", {31'd0, ds_m}, 32'd0);  // cycle after the pulse
  endtask

  // Drop the request and confirm the unit returns to idle.
  task automatic release_req(input bit big);
    if (big) ss_l = 1'b0; else ss_s = 1'b0;
    step();
    chk("idle_after_release", {31'd0, busy_m}, 32'd0);
  endtask

  logic [8*NB_L-1:0] big_data;

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    sel_l = 1'b0;

    // Reset held with the request high: nothing may happen.
    for (int r = 0; r < 3; r++) begin
      step();
      chk("rst_wr",    {31'd0, wr_s},   32'd0);
      chk("rst_ds",    {31'd0, ds_s},   32'd0);
      chk("rst_busy",  {31'd0, busy_s}, 32'd0);
      chk("rst_wdata", {24'd0, wd_s},   32'd0);
      chk("rst_busy_l", {31'd0, busy_l}, 32'd0);
    end
    reset = 1'b1;

    // Basic frame straight out of reset.
    run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'h44332211}, 0, -1);
    release_req(1'b0);

    // Backpressure after the second byte.
    run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'h44332211}, 1, -1);

    // Request still held: no retrigger, stays busy.
    for (int r = 0; r < 4; r++) begin
      step();
      chk("hold_busy", {31'd0, busy_s}, 32'd1);
      chk("hold_wr",   {31'd0, wr_s},   32'd0);
      chk("hold_ds",   {31'd0, ds_s},   32'd0);
    end
    release_req(1'b0);
    run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'hDDCCBBAA}, 0, -1);
    release_req(1'b0);

    // Snapshot: sendData changes mid-frame, original bytes still go out.
    run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'hC3A55A3C}, 3, -1);
    release_req(1'b0);

    // Abort after two bytes, then a fresh request resends from byte 0.
    run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'h44332211}, 0, 2);
    run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'h44332211}, 0, -1);
    release_req(1'b0);

    // Random data and random backpressure on the small instance.
    for (int t = 0; t < 4; t++) begin
      run_frame(1'b0, {{(8*(NB_L-NB_S)){1'b0}}, 32'($urandom)}, 2, -1);
      release_req(1'b0);
    end

    // Default-size frame under random tx_full.
    for (int k = 0; k < NB_L; k++) big_data[8*k +: 8] = 8'h5A;
    run_frame(1'b1, big_data, 2, -1);
    release_req(1'b1);

    // Default-size frame with random contents.
    for (int k = 0; k < NB_L; k++) big_data[8*k +: 8] = 8'($urandom);
    run_frame(1'b1, big_data, 2, -1);
    release_req(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
